// File: rtl/seq_lock_ctrl.sv
// Code-lock controller: serialises an accepted code MSB-first into an external Mealy detector and reports unlock/fail.
// Optional lockout after MAX_FAIL consecutive failures is enabled by defining SEQ_LOCK_LOCKOUT_EN.
module seq_lock_ctrl #(
  parameter int CODE_W      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            code_valid,
  input  logic [CODE_W-1:0]               code,
  output logic                            code_ready,
  output logic                            det_x,
  output logic                            det_reset,
  input  logic                            det_y,
  output logic                            unlock,
  output logic                            fail,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic                            locked,
  output logic [2:0]                      dbg_state
);

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int IW = $clog2(CODE_W);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, RESULT, LOCKOUT} state_t;

  state_t            state;
  logic [CODE_W-1:0] sh;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     timer;

`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
  assign locked = (state == LOCKOUT);
`else
  localparam bit LOCKOUT_EN = 1'b0;
  assign locked = 1'b0;
`endif

  assign dbg_state = state;

  // Handshake: a code transfers on a rising edge where code_valid and code_ready are both 1;
  // code_ready is high only in IDLE, so code_valid is ignored at all other times.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      idx        <= '0;
      timer      <= '0;
      fail_cnt   <= '0;
      code_ready <= 1'b1;
      det_reset  <= 1'b1;
      det_x      <= 1'b0;
      unlock     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      unlock <= 1'b0;
      fail   <= 1'b0;
      case (state)
        IDLE: begin
          if (code_valid) begin
            sh         <= code;
            code_ready <= 1'b0;
            state      <= CLR;
          end
        end
        CLR: begin
          // det_x is registered, so the first bit is loaded one cycle ahead of SHIFT.
          det_reset <= 1'b0;
          det_x     <= sh[CODE_W-1];
          sh        <= sh << 1;
          idx       <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (idx == IW'(CODE_W - 1)) begin
            det_reset <= 1'b1;
            det_x     <= 1'b0;
            unlock    <= det_y;
            fail      <= ~det_y;
            if (det_y)
              fail_cnt <= '0;
            else if (fail_cnt != FW'(MAX_FAIL))
              fail_cnt <= fail_cnt + FW'(1);
            state <= RESULT;
          end else begin
            det_x <= sh[CODE_W-1];
            sh    <= sh << 1;
            idx   <= idx + IW'(1);
          end
        end
        RESULT: begin
          if (LOCKOUT_EN && fail && (fail_cnt == FW'(MAX_FAIL))) begin
            timer <= TW'(LOCK_CYCLES - 1);
            state <= LOCKOUT;
          end else begin
            code_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            fail_cnt   <= '0;
            code_ready <= 1'b1;
            state      <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          code_ready <= 1'b1;
          det_reset  <= 1'b1;
          det_x      <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Directed bench for seq_lock_ctrl with a behavioural 1101 Mealy detector and a pulse scoreboard.
// Lockout scenario runs when SEQ_LOCK_LOCKOUT_EN is defined, saturation scenario otherwise.
module tb_seq_lock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [3:0] code;
  logic       code_ready;
  logic       det_x;
  logic       det_reset;
  logic       det_y;
  logic       unlock;
  logic       fail;
  logic [1:0] fail_cnt;
  logic       locked;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [1:0] exp_q[$];

  seq_lock_ctrl #(.CODE_W(4), .MAX_FAIL(3), .LOCK_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .det_x(det_x), .det_reset(det_reset), .det_y(det_y),
    .unlock(unlock), .fail(fail), .fail_cnt(fail_cnt), .locked(locked),
    .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // behavioural detector: accepts only 1101 after its reset, sticky on mismatch
  logic [2:0] det_st = 3'd0;
  logic [3:0] det_pat = 4'b1101;
  always @(posedge clk) begin
    if (det_reset)
      det_st <= 3'd0;
    else if (det_st < 3'd4 && det_x == det_pat[2'(3 - det_st)])
      det_st <= det_st + 3'd1;
    else
      det_st <= 3'd7;
  end
  assign det_y = !det_reset && (det_st == 3'd3) && det_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor: pops one expectation per unlock/fail pulse
  always @(negedge clk) begin
    logic [1:0] e;
    if (reset === 1'b0 && (unlock !== 1'b0 || fail !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, unlock, fail}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse", {30'd0, unlock, fail}, {30'd0, e});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (code_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, code_ready}, 32'd1);
  endtask

  task automatic send(input logic [3:0] c, input bit change, input bit exp_lock);
    bit match;
    wait_ready();
    code_valid = 1'b1;
    code = c;
    match = (c == 4'b1101);
    exp_q.push_back(match ? 2'b10 : 2'b01);
    if (match) exp_cnt = 0;
    else if (exp_cnt < 3) exp_cnt++;
    @(negedge clk);
    code_valid = 1'b0;
    chk("clr_det_reset", {31'd0, det_reset}, 32'd1);
    chk("clr_ready", {31'd0, code_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("shift_det_reset", {31'd0, det_reset}, 32'd0);
      chk("shift_det_x", {31'd0, det_x}, {31'd0, c[3-i]});
      if (change && i == 0) code = 4'b0000;
    end
    @(negedge clk);
    chk("result_ready", {31'd0, code_ready}, 32'd0);
    chk("result_det_reset", {31'd0, det_reset}, 32'd1);
    @(negedge clk);
    if (!exp_lock) begin
      chk("after_ready", {31'd0, code_ready}, 32'd1);
      chk("after_locked", {31'd0, locked}, 32'd0);
      chk("after_fail_cnt", {30'd0, fail_cnt}, exp_cnt);
    end else begin
      code_valid = 1'b1;
      code = 4'b1101;
      for (int k = 0; k < 16; k++) begin
        chk("lock_locked", {31'd0, locked}, 32'd1);
        chk("lock_ready", {31'd0, code_ready}, 32'd0);
        @(negedge clk);
      end
      code_valid = 1'b0;
      exp_cnt = 0;
      chk("unlock_locked", {31'd0, locked}, 32'd0);
      chk("unlock_ready", {31'd0, code_ready}, 32'd1);
      chk("unlock_fail_cnt", {30'd0, fail_cnt}, 32'd0);
    end
  endtask

  task automatic abort_mid_shift();
    wait_ready();
    code_valid = 1'b1;
    code = 4'b1101;
    @(negedge clk);
    code_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_state_shift", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    chk("abort_det_reset", {31'd0, det_reset}, 32'd1);
    chk("abort_det_x", {31'd0, det_x}, 32'd0);
    chk("abort_state_idle", {29'd0, dbg_state}, 32'd0);
    chk("abort_fail_cnt", {30'd0, fail_cnt}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_pulse", {30'd0, unlock, fail}, 32'd0);
      @(negedge clk);
    end
    chk("abort_ready", {31'd0, code_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    code = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_det_reset", {31'd0, det_reset}, 32'd1);
    chk("rst_det_x", {31'd0, det_x}, 32'd0);
    chk("rst_pulses", {30'd0, unlock, fail}, 32'd0);
    chk("rst_fail_cnt", {30'd0, fail_cnt}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, code_ready}, 32'd1);

    send(4'b1101, 1'b0, 1'b0);
    send(4'b1100, 1'b0, 1'b0);
    send(4'b1101, 1'b0, 1'b0);
    send(4'b1101, 1'b1, 1'b0);
    send(4'b1100, 1'b0, 1'b0);
    abort_mid_shift();

`ifdef SEQ_LOCK_LOCKOUT_EN
    send(4'b0111, 1'b0, 1'b0);
    send(4'b0111, 1'b0, 1'b0);
    send(4'b0111, 1'b0, 1'b1);
    send(4'b1101, 1'b0, 1'b0);
`else
    for (int i = 0; i < 5; i++) send(4'b0000, 1'b0, 1'b0);
    send(4'b1101, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
